l2_norm_sched: RTL
==================

Name: l2_norm_sched

Overview:
- Round-robin scheduler that shares one L2-norm engine (square/accumulate/sqrt pipeline, 8-bit elements, 10-bit root) between NREQ requesters.
- Each requester submits a vector length, then streams its 8-bit elements.
- The scheduler clears the engine and feeds the elements in order. It counts engine valid pulses and returns the final root with the requester ID.
- Sits between the requester fabric and the norm engine, and is the only driver of the engine's inputs.

Parameters:
- NREQ, 2, number of requesters (2..4)
- LEN_W, 5, width of the vector-length field
- MAX_LEN, 16, largest legal length; 16*255^2 fits the engine's 20-bit accumulator
- WDOG, 8, cycles allowed in DRAIN before an error is flagged

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NREQ  requester i has a pending vector
- req_len  in  NREQ*LEN_W  length for requester i, in slice i
- req_ready  out  NREQ  one-cycle pulse: length of requester i accepted
- elem_data  in  NREQ*8  element stream, slice i
- elem_valid  in  NREQ  element valid
- elem_ready  out  NREQ  element accepted when valid&&ready
- res_valid  out  1  one-cycle result pulse
- res_id  out  $clog2(NREQ)  requester owning the result
- res_data  out  10  L2 norm (floor sqrt of sum of squares)
- res_err  out  1  qualifies res_valid: illegal length or watchdog timeout
- eng_reset  out  1  engine synchronous clear, active-high
- eng_a  out  8  engine element
- eng_valid_in  out  1  engine input valid
- eng_g  in  10  engine root output
- eng_valid_out  in  1  engine output valid; eng_g is valid while it is high

Behaviour:
- Reset values (reset=0, async):
  - state=IDLE, grant pointer=0
  - req_ready=0, elem_ready=0, res_valid=0, res_id=0, res_data=0, res_err=0, eng_valid_in=0, eng_a=0
  - eng_reset=1
- Outputs: all registered except elem_ready and eng_valid_in, which are combinational from state and elem_valid. eng_a muxes elem_data[gnt].
- FSM:
  - IDLE: if any req_valid, pick the first requester at or after ptr+1 (mod NREQ), rotating. Latch gnt and len, pulse req_ready[gnt].
    - len==0 -> RESULT with data 0, err 0.
    - len>MAX_LEN -> RESULT with data 0, err 1.
    - Otherwise -> CLEAR.
    - ptr<=gnt in all three cases.
  - CLEAR: eng_reset=1 for exactly one cycle -> STREAM. eng_reset=0 in every other non-reset state.
  - STREAM:
    - elem_ready[gnt]=1 while remaining>0. Other elem_ready bits are 0.
    - eng_valid_in = elem_valid[gnt]&&elem_ready[gnt], with eng_a=elem_data[gnt].
    - Each accepted element decrements remaining. Bubbles are allowed.
    - When the last element is accepted -> DRAIN.
  - DRAIN:
    - Counts eng_valid_out pulses, including any that arrived during STREAM. This count starts at 0 in CLEAR.
    - When count reaches len, capture eng_g into res_data -> RESULT.
    - If WDOG cycles pass in DRAIN without completion -> RESULT with err=1, data=0.
  - RESULT: res_valid=1 for one cycle with res_id=gnt -> IDLE.
- Latency:
  - Engine valid_out follows valid_in by 3 cycles.
  - res_valid is asserted 5 cycles after the last element handshake (last handshake edge+3 = pulse; the next edge transitions DRAIN->RESULT).
- Arbitration: a new arbitration happens only in IDLE, so there is at most one vector in flight. A requester with req_valid held high is served again only after every other pending requester has been served.
- Simultaneous events: a requester deasserting req_valid while granted has no effect on the transfer in progress; the latched len governs.
- Reset mid-operation: abort immediately, no result is emitted, eng_reset=1 (engine cleared). After release, the FSM starts in IDLE with ptr=0.

Test Plan:
- Single vector: requester 0 sends len=2, elements {3,4} -> req_ready[0] pulse; eng_reset one cycle; res_valid with res_id=0, res_data=5, res_err=0 five cycles after the element 4 handshake.
- Bubbles and sequencing: requester 1 sends len=3, {1,2,2}, with a one-cycle elem_valid gap -> three eng_valid_in pulses; res_data=3. A following len=1, {7} vector -> res_data=7 (engine cleared between vectors, no carry-over).
- Arbitration: both requesters held valid with len=1 from reset -> grants alternate 1,0,1,0 (ptr starts at 0); results return in grant order.
- Boundary: len=16, all elements 255 -> res_data=1020. len=0 -> res_data=0, err=0, no eng_valid_in. len=17 -> err=1, no elements accepted.
- Watchdog: eng_valid_out tied low, len=1 -> res_err=1 after WDOG cycles in DRAIN.
- Reset in STREAM after 1 of 3 elements -> no res_valid; all outputs at reset values with eng_reset=1. After release, len=2 {6,8} -> res_data=10.

Source files
------------

// File: rtl/l2_norm_sched.sv
// l2_norm_sched: round-robin scheduler sharing one L2-norm engine among NREQ requesters
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_len/req_ready     : per-requester length handshake (req_ready is a one-cycle pulse)
//   elem_data/elem_valid/elem_ready : per-requester element stream, only the granted lane is ready
//   res_valid/res_id/res_data/res_err : one-cycle result pulse with owner, root and error flag
//   eng_reset/eng_a/eng_valid_in    : engine clear and element feed
//   eng_g/eng_valid_out             : engine root and its valid strobe
module l2_norm_sched #(
    parameter int NREQ    = 2,
    parameter int LEN_W   = 5,
    parameter int MAX_LEN = 16,
    parameter int WDOG    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*8-1:0]       elem_data,
    input  logic [NREQ-1:0]         elem_valid,
    output logic [NREQ-1:0]         elem_ready,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [9:0]              res_data,
    output logic                    res_err,
    output logic                    eng_reset,
    output logic [7:0]              eng_a,
    output logic                    eng_valid_in,
    input  logic [9:0]              eng_g,
    input  logic                    eng_valid_out
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(WDOG + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

    state_t           state;
    logic [IW-1:0]    ptr, gnt, pick;
    logic [LEN_W-1:0] len, rem, cnt, pick_len;
    logic [WW-1:0]    wd;
    logic [9:0]       val;
    logic             err, hs;

    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        pick = ptr;
        for (int k = NREQ; k >= 1; k--)
            if (req_valid[(int'(ptr) + k) % NREQ])
                pick = IW'((int'(ptr) + k) % NREQ);
    end

    assign pick_len = req_len[pick*LEN_W +: LEN_W];

    always_comb begin
        elem_ready = '0;
        elem_ready[gnt] = (state == STREAM) && (rem != '0);
    end

    assign hs           = elem_valid[gnt] && elem_ready[gnt];
    assign eng_valid_in = hs;
    assign eng_a        = (state == STREAM) ? elem_data[gnt*8 +: 8] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            len       <= '0;
            rem       <= '0;
            cnt       <= '0;
            wd        <= '0;
            val       <= '0;
            err       <= 1'b0;
            req_ready <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            eng_reset <= 1'b1;
        end else begin
            req_ready <= '0;
            res_valid <= 1'b0;
            eng_reset <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    gnt            <= pick;
                    ptr            <= pick;
                    len            <= pick_len;
                    rem            <= pick_len;
                    req_ready[pick] <= 1'b1;
                    val            <= '0;
                    err            <= int'(pick_len) > MAX_LEN;
                    if (pick_len == '0 || int'(pick_len) > MAX_LEN) begin
                        state <= RESULT;
                    end else begin
                        eng_reset <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= STREAM;
                end
                // Engine pulses for early elements can land while later ones are still streaming.
                STREAM: begin
                    if (eng_valid_out)
                        cnt <= cnt + 1'b1;
                    if (hs) begin
                        rem <= rem - 1'b1;
                        if (rem == 1) begin
                            wd    <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (eng_valid_out && (cnt + 1'b1 >= len)) begin
                        val   <= eng_g;
                        state <= RESULT;
                    end else if (wd == WW'(WDOG - 1)) begin
                        err   <= 1'b1;
                        state <= RESULT;
                    end else begin
                        wd  <= wd + 1'b1;
                        cnt <= cnt + LEN_W'(eng_valid_out);
                    end
                end
                RESULT: begin
                    res_valid <= 1'b1;
                    res_id    <= gnt;
                    res_data  <= val;
                    res_err   <= err;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
